// File: rtl/ilm_pkg.sv
// Shared types and helpers for the iterative logarithmic multiplier.
package ilm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  // Widest magnitude the leading-one detector has to cover.
  localparam int unsigned LOD_W = 32;

  // Index of the most significant set bit; 0 for an all-zero input.
  function automatic logic [5:0] lod(input logic [LOD_W-1:0] v);
    logic [5:0] idx;
    idx = '0;
    for (int i = 0; i < LOD_W; i++) begin
      if (v[i]) idx = 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ilm_iter_if.sv
// Operand/result handshake bundle for ilm_iter.
interface ilm_iter_if #(
  parameter int WIDTH  = 8,
  parameter int ITER_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH:0]    in1;
  logic [WIDTH:0]    in2;
  logic [ITER_W-1:0] iters;
  logic              out_valid;
  logic              out_ready;
  logic              sign;
  logic [2*WIDTH-1:0] product;
  logic              exact;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, in1, in2, iters, out_ready,
    input  in_ready, out_valid, sign, product, exact
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, in1, in2, iters, out_ready,
    output in_ready, out_valid, sign, product, exact
  );
endinterface

// File: rtl/ilm_term.sv
// One Mitchell/ILM correction term: strips the leading one from each
// residual and forms the partial product those leading ones contribute.
module ilm_term
  import ilm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   r1,
  input  logic [WIDTH-1:0]   r2,
  output logic [2*WIDTH-1:0] term,
  output logic [WIDTH-1:0]   q1,
  output logic [WIDTH-1:0]   q2,
  output logic               zero
);
  localparam int PW = 2 * WIDTH;

  logic [5:0] k1;
  logic [5:0] k2;

  // Leading-one detect, residual strip and three-input add.
  always_comb begin
    k1   = lod(LOD_W'(r1));
    k2   = lod(LOD_W'(r2));
    // Clearing the leading bit equals r - 2^k for any nonzero r, and
    // stays well defined (0) if a zero residual ever reaches this block.
    q1   = r1 & ~(WIDTH'(1) << k1);
    q2   = r2 & ~(WIDTH'(1) << k2);
    term = (PW'(1) << (k1 + k2)) + (PW'(q1) << k2) + (PW'(q2) << k1);
    zero = (q1 == '0) || (q2 == '0);
  end

endmodule

// File: rtl/ilm_iter.sv
// Iterative logarithmic multiplier for sign-magnitude operands: one
// correction term per clock, early exit once the residual product is zero.
module ilm_iter
  import ilm_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_ITER = 4,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input logic       clk,
  input logic       rst_n,
  ilm_iter_if.slave bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   r1_q, r1_d;
  logic [WIDTH-1:0]   r2_q, r2_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [ITER_W-1:0]  left_q, left_d;
  logic               s_q, s_d;
  logic               exact_q, exact_d;

  logic [ITER_W-1:0]  n_eff;
  logic [2*WIDTH-1:0] term;
  logic [WIDTH-1:0]   q1;
  logic [WIDTH-1:0]   q2;
  logic               t_zero;

  ilm_term #(.WIDTH(WIDTH)) u_term (
    .r1  (r1_q),
    .r2  (r2_q),
    .term(term),
    .q1  (q1),
    .q2  (q2),
    .zero(t_zero)
  );

  // Requested term count: 0 means one term, oversize requests clamp.
  always_comb begin
    if (bus.iters == '0)                        n_eff = ITER_W'(1);
    else if (bus.iters > ITER_W'(MAX_ITER))     n_eff = ITER_W'(MAX_ITER);
    else                                        n_eff = bus.iters;
  end

  // Next-state and datapath update for the accept / iterate / drain sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    acc_d   = acc_q;
    left_d  = left_q;
    s_d     = s_q;
    exact_d = exact_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          r1_d   = bus.in1[WIDTH-1:0];
          r2_d   = bus.in2[WIDTH-1:0];
          acc_d  = '0;
          left_d = n_eff;
          s_d    = bus.in1[WIDTH] ^ bus.in2[WIDTH];
          if ((bus.in1[WIDTH-1:0] == '0) || (bus.in2[WIDTH-1:0] == '0)) begin
            state_d = DONE;
            exact_d = 1'b1;
          end else begin
            state_d = CALC;
            exact_d = 1'b0;
          end
        end
      end
      CALC: begin
        acc_d  = acc_q + term;
        r1_d   = q1;
        r2_d   = q2;
        left_d = left_q - ITER_W'(1);
        if (t_zero) begin
          state_d = DONE;
          exact_d = 1'b1;
        end else if (left_q == ITER_W'(1)) begin
          state_d = DONE;
          exact_d = 1'b0;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      acc_q   <= '0;
      left_q  <= '0;
      s_q     <= 1'b0;
      exact_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      acc_q   <= acc_d;
      left_q  <= left_d;
      s_q     <= s_d;
      exact_q <= exact_d;
    end
  end

  // Result is presented only in DONE; a zero product never reports negative.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.product   = bus.out_valid ? acc_q : '0;
  assign bus.sign      = bus.out_valid && s_q && (acc_q != '0);
  assign bus.exact     = bus.out_valid && exact_q;

endmodule

// File: tb/tb_ilm_iter.sv
// Self-checking bench for ilm_iter (WIDTH=8, MAX_ITER=4).
module tb_ilm_iter;
  localparam int WIDTH    = 8;
  localparam int MAX_ITER = 4;
  localparam int ITER_W   = $clog2(MAX_ITER + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ilm_iter_if #(.WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

  ilm_iter #(.WIDTH(WIDTH), .MAX_ITER(MAX_ITER), .ITER_W(ITER_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input string item,
                       input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", name, item, act, exp, $time);
    end
  endtask

  // Reference: each term removes the leading powers of two p1, p2 from the
  // residuals a, b; after the loop the true product minus the leftover
  // residual product is what has been accumulated.
  function automatic void model(input int unsigned a, input int unsigned b,
                                input int unsigned it,
                                output longint unsigned prod, output int m,
                                output bit ex);
    longint unsigned ra, rb, pa, pb;
    int unsigned n;
    n  = (it == 0) ? 1 : ((it > MAX_ITER) ? MAX_ITER : it);
    ra = a;
    rb = b;
    m  = 0;
    if (a == 0 || b == 0) begin
      prod = 0;
      ex   = 1'b1;
      return;
    end
    while (m < int'(n) && ra != 0 && rb != 0) begin
      pa = 1; while (pa * 2 <= ra) pa *= 2;
      pb = 1; while (pb * 2 <= rb) pb *= 2;
      ra -= pa;
      rb -= pb;
      m++;
    end
    prod = longint'(a) * longint'(b) - ra * rb;
    ex   = (ra == 0 || rb == 0);
  endfunction

  typedef struct {
    longint unsigned prod;
    bit              sgn;
    bit              ex;
    int              lat;
  } exp_t;

  exp_t exp_q[$];
  int   since = 0;
  bit   first_seen = 1'b0;

  // Scoreboard: predict at acceptance, compare every cycle a result is shown.
  always @(negedge clk) begin
    exp_t e;
    longint unsigned p;
    int m;
    bit ex;
    if (!rst_n) begin
      exp_q.delete();
      first_seen = 1'b0;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("cmp", "unexpected_out_valid", 1, 0);
        end else begin
          if (!first_seen) begin
            check("cmp", "latency", longint'(since), longint'(exp_q[0].lat));
            first_seen = 1'b1;
          end
          check("cmp", "product", bus.product, exp_q[0].prod);
          check("cmp", "sign", bus.sign, exp_q[0].sgn);
          check("cmp", "exact", bus.exact, exp_q[0].ex);
          check("cmp", "in_ready_low", bus.in_ready, 0);
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            first_seen = 1'b0;
          end
        end
      end
      since++;
      if (bus.in_valid && bus.in_ready) begin
        model(bus.in1[WIDTH-1:0], bus.in2[WIDTH-1:0], bus.iters, p, m, ex);
        e.prod = p;
        e.sgn  = (bus.in1[WIDTH] ^ bus.in2[WIDTH]) && (p != 0);
        e.ex   = ex;
        e.lat  = m;
        exp_q.push_back(e);
        since = 0;
      end
    end
  end

  // One operation with hand-computed expectations; hold>0 stalls the drain.
  task automatic run_op(input string name, input bit s1, input int m1,
                        input bit s2, input int m2, input int it,
                        input longint unsigned ep, input bit es, input bit ee,
                        input int el, input int hold);
    int lat;
    @(posedge clk); #1;
    bus.in1       = {s1, WIDTH'(m1)};
    bus.in2       = {s2, WIDTH'(m2)};
    bus.iters     = ITER_W'(it);
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    lat = 0;
    while (!bus.in_ready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, "in_ready", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check(name, "out_valid", bus.out_valid, 1);
    check(name, "latency", longint'(lat), longint'(el));
    check(name, "product", bus.product, ep);
    check(name, "sign", bus.sign, es);
    check(name, "exact", bus.exact, ee);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.in1      = {1'b0, WIDTH'(9)};
        bus.in2      = {1'b0, WIDTH'(9)};
        @(posedge clk); #1;
        check(name, "hold_out_valid", bus.out_valid, 1);
        check(name, "hold_product", bus.product, ep);
        check(name, "hold_sign", bus.sign, es);
        check(name, "hold_exact", bus.exact, ee);
        check(name, "hold_in_ready", bus.in_ready, 0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check(name, "back_to_idle", bus.in_ready, 1);
    check(name, "valid_dropped", bus.out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    longint unsigned p;
    int m;
    bit ex;
    int ov_count;

    bus.in_valid  = 1'b0;
    bus.in1       = '0;
    bus.in2       = '0;
    bus.iters     = '0;
    bus.out_ready = 1'b1;

    // Pin the model itself against hand arithmetic.
    model(3, 3, 1, p, m, ex);
    check("model", "3x3_i1", p, 8);
    model(255, 255, 7, p, m, ex);
    check("model", "255x255_i7", p, 64800);
    check("model", "255x255_terms", longint'(m), 4);
    model(128, 77, 4, p, m, ex);
    check("model", "128x77_exact", ex, 1);

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    check("reset", "in_ready", bus.in_ready, 1);
    check("reset", "out_valid", bus.out_valid, 0);
    check("reset", "product", bus.product, 0);
    check("reset", "sign", bus.sign, 0);
    check("reset", "exact", bus.exact, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    //     name          s1 m1   s2 m2   it  prod   sgn ex lat hold
    run_op("mul3x3_i1",  0, 3,   0, 3,   1,  8,     0,  0, 1,  0);
    run_op("mul3x3_i2",  0, 3,   0, 3,   2,  9,     0,  1, 2,  0);
    run_op("mul3x3_i0",  0, 3,   0, 3,   0,  8,     0,  0, 1,  0);
    run_op("clamp_i7",   0, 255, 1, 255, 7,  64800, 1,  0, 4,  0);
    run_op("worst_i1",   0, 255, 1, 255, 1,  48896, 1,  0, 1,  0);
    run_op("early_exit", 0, 128, 0, 77,  4,  9856,  0,  1, 1,  0);
    run_op("neg_zero",   1, 0,   0, 5,   3,  0,     0,  1, 0,  0);
    run_op("neg7_neg7",  1, 7,   1, 7,   3,  49,    0,  1, 3,  0);
    run_op("backpress",  0, 200, 1, 13,  2,  2592,  1,  0, 2,  5);

    // Reset during the second iteration of 255x255.
    @(posedge clk); #1;
    bus.in1       = {1'b0, WIDTH'(255)};
    bus.in2       = {1'b0, WIDTH'(255)};
    bus.iters     = ITER_W'(4);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;          // accepting edge
    bus.in_valid = 1'b0;
    @(posedge clk); #2;          // first term done, second in progress
    check("rst_mid", "in_calc", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid", "in_ready", bus.in_ready, 1);
    check("rst_mid", "out_valid", bus.out_valid, 0);
    check("rst_mid", "product", bus.product, 0);
    check("rst_mid", "sign", bus.sign, 0);
    check("rst_mid", "exact", bus.exact, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ov_count = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) ov_count++;
    end
    check("rst_mid", "no_valid_after", longint'(ov_count), 0);

    // Normal operation resumes after the aborted one.
    run_op("after_rst",  0, 5,   0, 6,   4,  30,    0,  1, 2,  0);

    repeat (3) @(posedge clk);
    check("end", "scoreboard_empty", longint'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
